// File: rtl/serial_addsub.sv
// ============================================================================
// serial_addsub
// ----------------------------------------------------------------------------
// Bit-serial adder/subtractor. A single 1-bit full add/sub cell plus a
// carry/borrow flip-flop process the captured operands LSB first, one bit per
// clock. The result is assembled in a shift register and published to
// sumdiff/carryborrowOut only when the last bit has been processed, so no
// partial result is ever visible on the outputs.
//
// Ports
//   clk             : single clock, all state changes on the rising edge
//   rstn            : asynchronous active-low reset
//   start           : request a new operation (honoured in IDLE and DONE)
//   modeAddSubtract : 0 = a + b + cin, 1 = a - b - bin
//   a, b            : WIDTH-bit operands, captured with start
//   carryborrowIn   : carry-in (add) / borrow-in (subtract), captured with start
//   busy            : high while bits are being processed (SHIFT state)
//   done            : one-cycle pulse, result valid (DONE state)
//   sumdiff         : registered WIDTH-bit sum/difference (modulo 2^WIDTH)
//   carryborrowOut  : registered final carry (add) / borrow (subtract)
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             modeAddSubtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryborrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sumdiff,
    output logic             carryborrowOut
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] bitCnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] capA_r;
    logic [WIDTH-1:0] capB_r;
    logic             capMode_r;
    logic [WIDTH-1:0] shiftReg_r;
    logic [WIDTH-1:0] sumdiff_r;
    logic             carryborrowOut_r;
    logic             busy_r;
    logic             done_r;

    logic             dBit_s;
    logic             nextCarry_s;
    logic [WIDTH-1:0] shiftNext_s;
    logic             lastBit_s;

    // One-bit full add/sub cell: returns {next carry/borrow, result bit}.
    function automatic logic [1:0] addSubCell(input logic ai, input logic bi,
                                              input logic ci, input logic sub);
        logic d;
        logic c;
        d = ai ^ bi ^ ci;
        if (sub) begin
            c = (~ai & bi) | (ci & ~(ai ^ bi));
        end else begin
            c = (ai & bi) | (ci & (ai ^ bi));
        end
        return {c, d};
    endfunction

    // Bit cell evaluation on the current LSBs of the captured operands.
    always_comb begin
        dBit_s      = 1'b0;
        nextCarry_s = 1'b0;
        {nextCarry_s, dBit_s} = addSubCell(capA_r[0], capB_r[0], carry_r, capMode_r);
        // Result enters at the MSB and moves right, so after WIDTH shifts the
        // first (LSB) result bit sits in bit 0.
        shiftNext_s = {dBit_s, shiftReg_r[WIDTH-1:1]};
        lastBit_s   = (bitCnt_r == CNT_W'(WIDTH - 1));
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r          <= IDLE;
            bitCnt_r         <= '0;
            carry_r          <= 1'b0;
            capA_r           <= '0;
            capB_r           <= '0;
            capMode_r        <= 1'b0;
            shiftReg_r       <= '0;
            sumdiff_r        <= '0;
            carryborrowOut_r <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Capture operation; the carry flip-flop holds cin/bin.
                        capA_r    <= a;
                        capB_r    <= b;
                        capMode_r <= modeAddSubtract;
                        carry_r   <= carryborrowIn;
                        bitCnt_r  <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    // Operands shift right so the cell always reads bit 0.
                    capA_r     <= capA_r >> 1;
                    capB_r     <= capB_r >> 1;
                    carry_r    <= nextCarry_s;
                    shiftReg_r <= shiftNext_s;
                    bitCnt_r   <= bitCnt_r + CNT_W'(1);
                    if (lastBit_s) begin
                        sumdiff_r        <= shiftNext_s;
                        carryborrowOut_r <= nextCarry_s;
                        busy_r           <= 1'b0;
                        done_r           <= 1'b1;
                        state_r          <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign sumdiff        = sumdiff_r;
    assign carryborrowOut = carryborrowOut_r;

endmodule

// File: tb/tb_serial_addsub.sv
// ============================================================================
// tb_serial_addsub
// ----------------------------------------------------------------------------
// Self-checking bench for serial_addsub (WIDTH = 8). Expected results come
// from a plain-arithmetic model (a + b + cin, a - b - bin in 9 bits).
// Inputs change #1 after a rising edge; outputs are sampled there too.
// ============================================================================
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       modeAddSubtract;
    logic [7:0] a;
    logic [7:0] b;
    logic       carryborrowIn;
    logic       busy;
    logic       done;
    logic [7:0] sumdiff;
    logic       carryborrowOut;

    int total = 0;
    int bad   = 0;

    // Last published result, to check that outputs hold during SHIFT.
    logic [7:0] lastSum = 8'h00;
    logic       lastCo  = 1'b0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .modeAddSubtract(modeAddSubtract),
        .a(a), .b(b), .carryborrowIn(carryborrowIn), .busy(busy), .done(done),
        .sumdiff(sumdiff), .carryborrowOut(carryborrowOut)
    );

    always #5 clk = ~clk;

    // Reference: bit 8 is carry-out for add, borrow (negative) for subtract.
    function automatic logic [8:0] refModel(input logic [7:0] x, input logic [7:0] y,
                                            input logic m, input logic c);
        logic [8:0] r;
        if (m == 1'b0) r = {1'b0, x} + {1'b0, y} + {8'd0, c};
        else           r = {1'b0, x} - {1'b0, y} - {8'd0, c};
        return r;
    endfunction

    // Launch one operation and wait (bounded) for done. edges counts the start
    // edge inclusive; busyCyc counts sampled cycles with busy high.
    task automatic doOp(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                        input logic ic, output int edges, output int busyCyc,
                        output logic partialBad, output logic timeout);
        @(negedge clk);
        a = ia; b = ib; modeAddSubtract = im; carryborrowIn = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        modeAddSubtract = 1'($urandom); carryborrowIn = 1'($urandom);
        edges = 1; busyCyc = 0; partialBad = 1'b0; timeout = 1'b1;
        if (busy) busyCyc++;
        if (sumdiff !== lastSum || carryborrowOut !== lastCo) partialBad = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busyCyc++;
            if (sumdiff !== lastSum || carryborrowOut !== lastCo) partialBad = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; modeAddSubtract = 1'b0;
        a = 8'h00; b = 8'h00; carryborrowIn = 1'b0;
        #12;
        total++;
        if ({busy, done, carryborrowOut, sumdiff} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b co=%b sum=%h, want all 0",
                     busy, done, carryborrowOut, sumdiff);
        end
        @(negedge clk); rstn = 1'b1;
        lastSum = 8'h00; lastCo = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] va [6] = '{8'h35, 8'hFF, 8'hFF, 8'h10, 8'h00, 8'h05};
        logic [7:0] vb [6] = '{8'h4A, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h03};
        logic       vm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] es [6] = '{8'h7F, 8'h00, 8'hFF, 8'h0F, 8'hFF, 8'h01};
        logic       ec [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        int edges, busyCyc;
        logic partialBad, timeout;
        for (int k = 0; k < 6; k++) begin
            doOp(va[k], vb[k], vm[k], vc[k], edges, busyCyc, partialBad, timeout);
            total++;
            if (timeout || sumdiff !== es[k] || carryborrowOut !== ec[k]) begin
                bad++;
                $display("FAIL directed_%0d: got sum=%h co=%b timeout=%b, want sum=%h co=%b",
                         k, sumdiff, carryborrowOut, timeout, es[k], ec[k]);
            end
            total++;
            if (edges != 9 || busyCyc != 8) begin
                bad++;
                $display("FAIL latency_%0d: got edges=%0d busy=%0d, want 9 and 8",
                         k, edges, busyCyc);
            end
            total++;
            if (partialBad) begin
                bad++;
                $display("FAIL hold_%0d: got outputs changing during SHIFT, want held", k);
            end
            lastSum = es[k]; lastCo = ec[k];
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || sumdiff !== es[k]) begin
                bad++;
                $display("FAIL pulse_%0d: got done=%b busy=%b sum=%h, want 0 0 %h",
                         k, done, busy, sumdiff, es[k]);
            end
        end
    endtask

    task automatic test_random();
        int edges, busyCyc;
        logic partialBad, timeout;
        logic [7:0] x, y;
        logic m, c;
        logic [8:0] exp9;
        for (int k = 0; k < 40; k++) begin
            x = 8'($urandom); y = 8'($urandom); m = 1'($urandom); c = 1'($urandom);
            exp9 = refModel(x, y, m, c);
            doOp(x, y, m, c, edges, busyCyc, partialBad, timeout);
            total++;
            if (timeout || partialBad || {carryborrowOut, sumdiff} !== exp9) begin
                bad++;
                $display("FAIL random_%0d: a=%h b=%h m=%b c=%b got %b_%h want %b_%h", k,
                         x, y, m, c, carryborrowOut, sumdiff, exp9[8], exp9[7:0]);
            end
            lastSum = exp9[7:0]; lastCo = exp9[8];
        end
    endtask

    // Patterns cover every (a_i, b_i) combination in every bit lane.
    task automatic test_lanes();
        logic [7:0] pat [8] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h0F, 8'hF0, 8'h33, 8'hCC};
        int edges, busyCyc;
        logic partialBad, timeout;
        logic [8:0] exp9;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++) begin
                        exp9 = refModel(pat[i], pat[j], 1'(m), 1'(c));
                        doOp(pat[i], pat[j], 1'(m), 1'(c), edges, busyCyc, partialBad, timeout);
                        total++;
                        if (timeout || {carryborrowOut, sumdiff} !== exp9) begin
                            bad++;
                            $display("FAIL lanes: a=%h b=%h m=%0d c=%0d got %b_%h want %b_%h",
                                     pat[i], pat[j], m, c, carryborrowOut, sumdiff,
                                     exp9[8], exp9[7:0]);
                        end
                        lastSum = exp9[7:0]; lastCo = exp9[8];
                    end
    endtask

    task automatic test_ignore_start();
        logic [8:0] exp9;
        int edges;
        logic seen;
        exp9 = refModel(8'h9C, 8'h47, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'h9C; b = 8'h47; modeAddSubtract = 1'b1; carryborrowIn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'h11; b = 8'h22; modeAddSubtract = 1'b0; carryborrowIn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 5; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        total++;
        if (!seen || edges != 9 || {carryborrowOut, sumdiff} !== exp9) begin
            bad++;
            $display("FAIL ignore_start: got %b_%h at edge %0d seen=%b, want %b_%h at 9",
                     carryborrowOut, sumdiff, edges, seen, exp9[8], exp9[7:0]);
        end
        lastSum = exp9[7:0]; lastCo = exp9[8];
    endtask

    task automatic test_reset_mid();
        int edges, busyCyc;
        logic partialBad, timeout, sawDone;
        logic [8:0] exp9;
        @(negedge clk);
        a = 8'hE7; b = 8'h3B; modeAddSubtract = 1'b0; carryborrowIn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({busy, done, carryborrowOut, sumdiff} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b done=%b co=%b sum=%h, want all 0",
                     busy, done, carryborrowOut, sumdiff);
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        lastSum = 8'h00; lastCo = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) sawDone = 1'b1;
        end
        total++;
        if (sawDone) begin
            bad++;
            $display("FAIL abort_no_done: got done/busy after reset, want none");
        end
        exp9 = refModel(8'hE7, 8'h3B, 1'b0, 1'b1);
        doOp(8'hE7, 8'h3B, 1'b0, 1'b1, edges, busyCyc, partialBad, timeout);
        total++;
        if (timeout || edges != 9 || {carryborrowOut, sumdiff} !== exp9) begin
            bad++;
            $display("FAIL after_reset: got %b_%h edges=%0d, want %b_%h edges=9",
                     carryborrowOut, sumdiff, edges, exp9[8], exp9[7:0]);
        end
        lastSum = exp9[7:0]; lastCo = exp9[8];
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp1, exp2;
        int edges;
        logic seen;
        exp1 = refModel(8'hC8, 8'h64, 1'b0, 1'b0);
        exp2 = refModel(8'h20, 8'h31, 1'b1, 1'b1);
        @(negedge clk);
        a = 8'hC8; b = 8'h64; modeAddSubtract = 1'b0; carryborrowIn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || {carryborrowOut, sumdiff} !== exp1) begin
            bad++;
            $display("FAIL b2b_first: got %b_%h seen=%b, want %b_%h",
                     carryborrowOut, sumdiff, seen, exp1[8], exp1[7:0]);
        end
        a = 8'h20; b = 8'h31; modeAddSubtract = 1'b1; carryborrowIn = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_restart: got busy=%b done=%b, want 1 0", busy, done);
        end
        edges = 1; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || edges != 9 || {carryborrowOut, sumdiff} !== exp2) begin
            bad++;
            $display("FAIL b2b_second: got %b_%h edges=%0d, want %b_%h edges=9",
                     carryborrowOut, sumdiff, edges, exp2[8], exp2[7:0]);
        end
        lastSum = exp2[7:0]; lastCo = exp2[8];
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_lanes();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rstn SHALL be: rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port start SHALL be: start  input  1  request new operation; sampled on rising clk.
REQ-005 Port modeAddSubtract SHALL be: modeAddSubtract  input  1  0 = add, 1 = subtract (a - b).
REQ-006 Port a SHALL be: a  input  WIDTH  first operand; captured with start.
REQ-007 Port b SHALL be: b  input  WIDTH  second operand; captured with start.
REQ-008 Port carryborrowIn SHALL be: carryborrowIn  input  1  carry-in (add) or borrow-in (subtract); captured with start.
REQ-009 Port busy SHALL be: busy  output  1  high while bits are being processed.
REQ-010 Port done SHALL be: done  output  1  one-cycle pulse; result valid.
REQ-011 Port sumdiff SHALL be: sumdiff  output  WIDTH  registered sum/difference.
REQ-012 Port carryborrowOut SHALL be: carryborrowOut  output  1  registered final carry (add) or borrow (subtract).

Function
REQ-013 The block SHALL be a bit-serial adder/subtractor: one 1-bit full add/sub cell plus a carry/borrow flip-flop, LSB first, one bit per clock.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; encoding is free.
REQ-015 IDLE or DONE with start=1 at an edge: capture a, b, modeAddSubtract, carryborrowIn into internal registers; clear bit counter; go to SHIFT.
REQ-016 IDLE with start=0: remain IDLE. DONE with start=0: go to IDLE.
REQ-017 SHIFT: each edge processes bit i (i = 0..WIDTH-1) of captured operands using captured mode and running carry/borrow c.
REQ-018 Bit cell: d = a_i ^ b_i ^ c; add next c = a_i&b_i | c&(a_i^b_i); subtract next c = ~a_i&b_i | c&~(a_i^b_i).
REQ-019 Result bit d SHALL enter an internal shift register so that after WIDTH SHIFT edges it holds the full result in natural bit order.
REQ-020 At the WIDTH-th SHIFT edge: load sumdiff with the full result and carryborrowOut with the final c; go to DONE.
REQ-021 Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH (WIDTH+1 edges inclusive); for WIDTH=8, 9 edges.
REQ-022 busy SHALL be high exactly in SHIFT; done SHALL be high exactly in DONE (one cycle).
REQ-023 sumdiff and carryborrowOut SHALL hold their last values in IDLE, SHIFT and DONE until the next WIDTH-th SHIFT edge; no partial results visible.
REQ-024 start while in SHIFT SHALL be ignored; captured operands and mode are unaffected by input changes after capture.
REQ-025 start in the DONE cycle SHALL begin a new operation back-to-back (no IDLE cycle).
REQ-026 Arithmetic is modulo 2^WIDTH; overflow only via carryborrowOut; no signed-overflow flag.

Reset
REQ-027 rstn=0 SHALL immediately, regardless of clk, force IDLE and clear counter, carry/borrow flip-flop, captured operands, shift register, sumdiff, carryborrowOut, busy, done to 0.
REQ-028 Reset during SHIFT SHALL abort the operation; no done pulse follows for it.
REQ-029 After rstn rises, the first start SHALL be accepted on the next rising edge.

Verification (WIDTH=8)
REQ-030 Add a=0x35, b=0x4A, cin=0 -> sumdiff=0x7F, carryborrowOut=0, done exactly 9 edges after start edge inclusive, busy high 8 cycles.
REQ-031 Add a=0xFF, b=0x01, cin=0 -> sumdiff=0x00, carryborrowOut=1; add a=0xFF, b=0xFF, cin=1 -> 0xFF, carryborrowOut=1.
REQ-032 Subtract a=0x10, b=0x01, bin=0 -> 0x0F, borrow 0; a=0x00, b=0x01, bin=0 -> 0xFF, borrow 1; a=0x05, b=0x03, bin=1 -> 0x01, borrow 0.
REQ-033 start pulsed mid-SHIFT with different a/b/mode -> ignored; result matches originally captured operation.
REQ-034 rstn low at 4th SHIFT cycle -> all outputs 0 asynchronously, no done; next start yields correct result.
REQ-035 start held high through DONE -> second operation begins in DONE cycle, second done 9 edges after first done; exhaustive 1-bit-per-lane check against a+b+cin / a-b-bin reference model.
